// File: rtl/lock_pkg.sv
// Shared definitions for the keypad entry front-end: key codes, buffer
// depth, FSM state encoding and the BCD digit type.
package lock_pkg;

  localparam int DIGITS = 6;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    JUDGE,
    PASS,
    LOCKOUT,
    CLEANUP
  } state_t;

  // Codes 0..9 are digits; everything above is a command or reserved.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_entry_sequencer_if.sv
// Bundle of keypad, display and lock-controller signals for the entry
// sequencer. The slave side is the sequencer itself; the master side is the
// keypad/lock-controller environment around it.
interface keypad_entry_sequencer_if;
  import lock_pkg::*;

  logic       key_valid;
  logic [3:0] key_code;
  digit_t     d1, d2, d3, d4, d5, d6;
  logic [2:0] count;
  logic       j;
  logic       res;
  logic       unlock;
  logic       fail;
  logic       entry_err;
  logic       locked_out;
  logic       busy;

  modport master (
    output key_valid, key_code, res,
    input  d1, d2, d3, d4, d5, d6, count, j, unlock, fail, entry_err,
           locked_out, busy
  );

  modport slave (
    input  key_valid, key_code, res,
    output d1, d2, d3, d4, d5, d6, count, j, unlock, fail, entry_err,
           locked_out, busy
  );

endinterface

// File: rtl/keypad_entry_sequencer_cycle_timer.sv
// Loadable down-counter with a done flag. Loaded on entry to a timed state;
// done is high once the count has run down to zero.
module cycle_timer #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] remaining;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      remaining <= '0;
    else if (load)
      remaining <= load_value;
    else if (remaining != '0)
      remaining <= remaining - WIDTH'(1);
  end

  assign done = (remaining == '0);

endmodule

// File: rtl/keypad_entry_sequencer.sv
// Keypad entry sequencer: collects six digits, strobes the lock controller,
// then shows unlock / failure and enforces lockout after repeated failures.
// Optional build macro AUTO_SUBMIT_EN: the sixth digit submits the entry
// without ENTER.
module keypad_entry_sequencer
  import lock_pkg::*;
#(
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES  = 50
) (
  input logic                     clk,
  input logic                     clr_n,
  keypad_entry_sequencer_if.slave bus
);

  localparam int MAX_CYC = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  state_t     state, state_nx;
  digit_t     digits    [DIGITS];
  digit_t     digits_nx [DIGITS];
  logic [2:0] count, count_nx;
  logic [3:0] fail_cnt, fail_cnt_nx;
  logic       fail_q, fail_nx;
  logic       entry_err_q, entry_err_nx;
  logic       timer_load;
  logic [TW-1:0] timer_value;
  logic       timer_done;

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .clr_n      (clr_n),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // State, digit buffer, fail counter and the one-cycle pulses.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      count       <= '0;
      fail_cnt    <= '0;
      fail_q      <= 1'b0;
      entry_err_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) digits[i] <= '0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      fail_cnt    <= fail_cnt_nx;
      fail_q      <= fail_nx;
      entry_err_q <= entry_err_nx;
      digits      <= digits_nx;
    end
  end

  // Next-state and buffer editing; keys only matter in IDLE and ENTRY.
  always_comb begin
    state_nx     = state;
    digits_nx    = digits;
    count_nx     = count;
    fail_cnt_nx  = fail_cnt;
    fail_nx      = 1'b0;
    entry_err_nx = 1'b0;
    timer_load   = 1'b0;
    timer_value  = '0;

    case (state)
      IDLE: begin
        if (bus.key_valid) begin
          if (is_digit(bus.key_code)) begin
            digits_nx[0] = bus.key_code;
            count_nx     = 3'd1;
            state_nx     = ENTRY;
          end else if (bus.key_code == KEY_ENTER) begin
            entry_err_nx = 1'b1;
          end
        end
      end

      ENTRY: begin
        if (bus.key_valid) begin
          if (is_digit(bus.key_code)) begin
            if (count < 3'(DIGITS)) begin
              digits_nx[count] = bus.key_code;
              count_nx         = count + 3'd1;
`ifdef AUTO_SUBMIT_EN
              if (count == 3'(DIGITS - 1)) state_nx = JUDGE;
`endif
            end
          end else if (bus.key_code == KEY_BKSP) begin
            digits_nx[count - 3'd1] = '0;
            count_nx                = count - 3'd1;
            if (count == 3'd1) state_nx = IDLE;
          end else if (bus.key_code == KEY_CLR) begin
            for (int i = 0; i < DIGITS; i++) digits_nx[i] = '0;
            count_nx = '0;
            state_nx = IDLE;
          end else if (bus.key_code == KEY_ENTER) begin
`ifdef AUTO_SUBMIT_EN
            entry_err_nx = 1'b1;
`else
            if (count < 3'(DIGITS)) entry_err_nx = 1'b1;
            else                    state_nx     = JUDGE;
`endif
          end
        end
      end

      JUDGE: begin
        if (bus.res) begin
          fail_cnt_nx = '0;
          state_nx    = PASS;
          timer_load  = 1'b1;
          timer_value = TW'(UNLOCK_CYCLES - 1);
        end else begin
          fail_nx     = 1'b1;
          fail_cnt_nx = fail_cnt + 4'd1;
          if ((fail_cnt + 4'd1) >= 4'(MAX_FAIL)) begin
            state_nx    = LOCKOUT;
            timer_load  = 1'b1;
            timer_value = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_nx = CLEANUP;
          end
        end
      end

      PASS: begin
        if (timer_done) state_nx = CLEANUP;
      end

      LOCKOUT: begin
        if (timer_done) begin
          fail_cnt_nx = '0;
          state_nx    = CLEANUP;
        end
      end

      CLEANUP: begin
        for (int i = 0; i < DIGITS; i++) digits_nx[i] = '0;
        count_nx = '0;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  assign bus.d1         = digits[0];
  assign bus.d2         = digits[1];
  assign bus.d3         = digits[2];
  assign bus.d4         = digits[3];
  assign bus.d5         = digits[4];
  assign bus.d6         = digits[5];
  assign bus.count      = count;
  assign bus.j          = (state == JUDGE);
  assign bus.unlock     = (state == PASS);
  assign bus.locked_out = (state == LOCKOUT);
  assign bus.busy       = (state != IDLE) && (state != ENTRY);
  assign bus.fail       = fail_q;
  assign bus.entry_err  = entry_err_q;

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Self-checking bench for keypad_entry_sequencer. A queue of entered digits
// and a running failure count stand in for the design; random key streams
// and random judge results are compared against them.
module tb_keypad_entry_sequencer;
  import lock_pkg::*;

  localparam int MAX_FAIL       = 3;
  localparam int LOCKOUT_CYCLES = 1000;
  localparam int UNLOCK_CYCLES  = 50;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;

  int checks = 0;
  int passes = 0;
  int q[$];
  int fail_model = 0;

  keypad_entry_sequencer_if bus ();

  keypad_entry_sequencer #(
    .MAX_FAIL       (MAX_FAIL),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  function automatic logic [23:0] obs_digits();
    return {bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6};
  endfunction

  function automatic logic [23:0] exp_digits();
    logic [23:0] r = '0;
    for (int i = 0; i < DIGITS; i++)
      if (i < q.size()) r[23 - 4*i -: 4] = 4'(q[i]);
    return r;
  endfunction

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // One key against the queue model; checks buffer, count, error pulse.
  task automatic press_and_check(input logic [3:0] code, input string tag);
    logic exp_err = 1'b0;
    if (code <= 4'd9) begin
      if (q.size() < DIGITS) q.push_back(int'(code));
    end else if (code == KEY_BKSP) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (code == KEY_CLR) begin
      q.delete();
    end else if (code == KEY_ENTER) begin
      exp_err = (q.size() < DIGITS);
    end
    press(code);
    checks++;
    if (obs_digits() !== exp_digits())
      $display("[TB] FAIL %s digits: got %h expected %h", tag, obs_digits(), exp_digits());
    else passes++;
    checks++;
    if (bus.count !== 3'(q.size()))
      $display("[TB] FAIL %s count: got %0d expected %0d", tag, bus.count, q.size());
    else passes++;
    checks++;
    if ({bus.entry_err, bus.j, bus.busy} !== {exp_err, 2'b00})
      $display("[TB] FAIL %s err/j/busy: got %b expected %b", tag,
               {bus.entry_err, bus.j, bus.busy}, {exp_err, 2'b00});
    else passes++;
  endtask

  // Full six-digit entry, submission and judgement with the given result.
  task automatic entry_and_judge(input logic [23:0] code_vec, input logic res_val,
                                 input bit keys_while_busy, input string tag);
    int cnt;
    bit changed;
    logic lock;
    logic [23:0] held;
    q.delete();
    bus.res = res_val;
    for (int i = 0; i < DIGITS - 1; i++) press_and_check(code_vec[23 - 4*i -: 4], tag);
`ifdef AUTO_SUBMIT_EN
    q.push_back(int'(code_vec[3:0]));
    press(code_vec[3:0]);
`else
    press_and_check(code_vec[3:0], tag);
    press(KEY_ENTER);
`endif
    checks++;
    if ({bus.j, bus.busy} !== 2'b11 || obs_digits() !== code_vec)
      $display("[TB] FAIL %s judge: got j/busy=%b digits=%h expected 11 %h", tag,
               {bus.j, bus.busy}, obs_digits(), code_vec);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.j !== 1'b0)
      $display("[TB] FAIL %s j_one_cycle: got %b expected 0", tag, bus.j);
    else passes++;
    held = code_vec;
    changed = 0;
    cnt = 0;
    if (res_val) begin
      fail_model = 0;
      checks++;
      if ({bus.unlock, bus.fail} !== 2'b10)
        $display("[TB] FAIL %s pass_entry: got unlock/fail=%b expected 10", tag, {bus.unlock, bus.fail});
      else passes++;
      while (bus.unlock === 1'b1 && cnt < UNLOCK_CYCLES + 20) begin
        cnt++;
        if (obs_digits() !== held) changed = 1;
        if (keys_while_busy) begin
          bus.key_valid = 1'($urandom_range(0, 1));
          bus.key_code  = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
      end
      bus.key_valid = 1'b0;
      checks++;
      if (cnt != UNLOCK_CYCLES)
        $display("[TB] FAIL %s unlock_len: got %0d expected %0d", tag, cnt, UNLOCK_CYCLES);
      else passes++;
    end else begin
      fail_model++;
      lock = (fail_model == MAX_FAIL);
      checks++;
      if ({bus.fail, bus.locked_out, bus.unlock} !== {1'b1, lock, 1'b0})
        $display("[TB] FAIL %s fail_entry: got fail/lock/unlock=%b expected %b", tag,
                 {bus.fail, bus.locked_out, bus.unlock}, {1'b1, lock, 1'b0});
      else passes++;
      if (lock) begin
        fail_model = 0;
        while (bus.locked_out === 1'b1 && cnt < LOCKOUT_CYCLES + 20) begin
          cnt++;
          if (obs_digits() !== held) changed = 1;
          if (keys_while_busy) begin
            bus.key_valid = 1'($urandom_range(0, 1));
            bus.key_code  = 4'($urandom_range(0, 15));
          end
          @(negedge clk);
        end
        bus.key_valid = 1'b0;
        checks++;
        if (cnt != LOCKOUT_CYCLES)
          $display("[TB] FAIL %s lockout_len: got %0d expected %0d", tag, cnt, LOCKOUT_CYCLES);
        else passes++;
      end
    end
    checks++;
    if (changed)
      $display("[TB] FAIL %s digits_stable: got changed=1 expected 0", tag);
    else passes++;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 5) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 1 || {bus.fail, bus.unlock, bus.locked_out, bus.busy} !== 4'b0000
        || bus.count !== 3'd0 || obs_digits() !== 24'h0)
      $display("[TB] FAIL %s back_to_idle: got cleanup=%0d flags=%b count=%0d digits=%h expected 1 0000 0 0",
               tag, cnt, {bus.fail, bus.unlock, bus.locked_out, bus.busy}, bus.count, obs_digits());
    else passes++;
    q.delete();
  endtask

  function automatic logic [23:0] random_code();
    logic [23:0] v;
    for (int i = 0; i < DIGITS; i++) v[23 - 4*i -: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic test_reset();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.res       = 1'b0;
    #1 clr_n = 1'b0;
    #11;
    checks++;
    if (obs_digits() !== 24'h0 || bus.count !== 3'd0)
      $display("[TB] FAIL reset_buffer: got %h/%0d expected 0/0", obs_digits(), bus.count);
    else passes++;
    checks++;
    if ({bus.j, bus.unlock, bus.fail, bus.entry_err, bus.locked_out, bus.busy} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {bus.j, bus.unlock, bus.fail, bus.entry_err, bus.locked_out, bus.busy});
    else passes++;
    @(negedge clk);
    clr_n = 1'b1;
    q.delete();
    fail_model = 0;
  endtask

  task automatic test_unlock();
    entry_and_judge(24'h123456, 1'b1, 1'b0, "unlock_directed");
  endtask

  task automatic test_backspace();
    press_and_check(4'd7, "bksp_a");
    press_and_check(4'd8, "bksp_b");
    press_and_check(KEY_BKSP, "bksp_c");
    press_and_check(4'd9, "bksp_d");
    checks++;
    if (obs_digits() !== 24'h790000 || bus.count !== 3'd2)
      $display("[TB] FAIL bksp_result: got %h/%0d expected 790000/2", obs_digits(), bus.count);
    else passes++;
    press_and_check(KEY_BKSP, "bksp_e");
    press_and_check(KEY_BKSP, "bksp_f");
    press_and_check(KEY_BKSP, "bksp_empty");
  endtask

  task automatic test_entry_err();
    press_and_check(4'd1, "err_a");
    press_and_check(4'd2, "err_b");
    press_and_check(4'd3, "err_c");
    press_and_check(KEY_ENTER, "err_enter");
    @(negedge clk);
    checks++;
    if ({bus.entry_err, bus.j} !== 2'b00 || bus.count !== 3'd3)
      $display("[TB] FAIL err_single_pulse: got err/j=%b count=%0d expected 00 3",
               {bus.entry_err, bus.j}, bus.count);
    else passes++;
    press_and_check(KEY_CLR, "err_clr");
  endtask

`ifndef AUTO_SUBMIT_EN
  task automatic test_overflow();
    for (int i = 1; i <= 7; i++) press_and_check(4'(i), $sformatf("ovf%0d", i));
    checks++;
    if (bus.d6 !== 4'd6 || bus.count !== 3'd6)
      $display("[TB] FAIL ovf_result: got d6=%0d count=%0d expected 6 6", bus.d6, bus.count);
    else passes++;
    press_and_check(KEY_CLR, "ovf_clr");
  endtask
`endif

  task automatic test_random_edit();
    logic [3:0] code;
    int sel;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4)      code = 4'($urandom_range(0, 9));
      else if (sel <= 6) code = KEY_BKSP;
      else if (sel == 7) code = KEY_CLR;
      else if (sel == 8) code = KEY_ENTER;
      else               code = 4'($urandom_range(13, 15));
      if (code == KEY_ENTER && q.size() == DIGITS) code = KEY_BKSP;
`ifdef AUTO_SUBMIT_EN
      if (code <= 4'd9 && q.size() == DIGITS - 1) code = KEY_BKSP;
`endif
      press_and_check(code, $sformatf("edit%0d", n));
    end
    press_and_check(KEY_CLR, "edit_clr");
  endtask

  task automatic test_lockout();
    for (int n = 0; n < MAX_FAIL; n++)
      entry_and_judge(random_code(), 1'b0, 1'b1, $sformatf("lock_fail%0d", n));
    entry_and_judge(random_code(), 1'b1, 1'b1, "lock_after");
  endtask

  task automatic test_random_judge();
    for (int n = 0; n < 8; n++)
      entry_and_judge(random_code(), 1'($urandom_range(0, 2) == 0), 1'b1,
                      $sformatf("rjudge%0d", n));
  endtask

  task automatic test_reset_during_pass();
    bus.res = 1'b1;
    for (int i = 1; i <= 5; i++) press(4'(i));
`ifdef AUTO_SUBMIT_EN
    press(4'd6);
`else
    press(4'd6);
    press(KEY_ENTER);
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (bus.unlock !== 1'b1)
      $display("[TB] FAIL rst_pass_setup: got unlock=%b expected 1", bus.unlock);
    else passes++;
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({bus.unlock, bus.j, bus.busy, bus.locked_out, bus.fail} !== 5'b0 ||
        obs_digits() !== 24'h0 || bus.count !== 3'd0)
      $display("[TB] FAIL rst_pass_abort: got flags=%b digits=%h count=%0d expected 00000 0 0",
               {bus.unlock, bus.j, bus.busy, bus.locked_out, bus.fail}, obs_digits(), bus.count);
    else passes++;
    @(negedge clk);
    clr_n = 1'b1;
    q.delete();
    fail_model = 0;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_backspace();
    test_entry_err();
`ifndef AUTO_SUBMIT_EN
    test_overflow();
`endif
    test_random_edit();
    test_lockout();
    test_random_judge();
    test_reset_during_pass();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
